// File: rtl/note_pkg.sv
// Shared constants for the note tone generator: half-period table, FSM encoding,
// code width and default articulation gap.
package note_pkg;

  localparam int unsigned CodeW         = 4;
  localparam int unsigned HpW           = 15;
  localparam int unsigned GapCycDefault = 2500;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StGap  = 2'd1;
  localparam state_t StPlay = 2'd2;

  // Middle-octave half-period counts in clk_5m cycles, do..ti.
  localparam logic [HpW-1:0] HpDo  = 15'd9555;
  localparam logic [HpW-1:0] HpRe  = 15'd8513;
  localparam logic [HpW-1:0] HpMi  = 15'd7584;
  localparam logic [HpW-1:0] HpFa  = 15'd7159;
  localparam logic [HpW-1:0] HpSol = 15'd6378;
  localparam logic [HpW-1:0] HpLa  = 15'd5682;
  localparam logic [HpW-1:0] HpTi  = 15'd5062;

  function automatic logic [HpW-1:0] med_hp(input logic [2:0] idx);
    case (idx)
      3'd1:    return HpDo;
      3'd2:    return HpRe;
      3'd3:    return HpMi;
      3'd4:    return HpFa;
      3'd5:    return HpSol;
      3'd6:    return HpLa;
      3'd7:    return HpTi;
      default: return '0;
    endcase
  endfunction

  function automatic logic code_valid(input logic [CodeW-1:0] med, input logic [CodeW-1:0] low);
    return (med < 4'd8) && (low < 4'd8) && ((med == '0) || (low == '0));
  endfunction

  // Half-period of a code pair; 0 means rest (including invalid pairs).
  function automatic logic [HpW-1:0] hp_lookup(input logic [CodeW-1:0] med,
                                               input logic [CodeW-1:0] low);
    if (!code_valid(med, low)) return '0;
    if (med != '0) return med_hp(med[2:0]);
    return med_hp(low[2:0]) << 1;
  endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// Signal bundle between the beat/note producer and the tone generator.
interface note_tone_gen_if;
  import note_pkg::*;

  logic                 beat;
  logic                 en;
  logic [CodeW-1:0]     med_code;
  logic [CodeW-1:0]     low_code;
  logic                 tone;
  logic                 playing;
  logic [2*CodeW-1:0]   cur_code;
  logic                 code_err;

  modport master (
    output beat, en, med_code, low_code,
    input  tone, playing, cur_code, code_err
  );

  modport slave (
    input  beat, en, med_code, low_code,
    output tone, playing, cur_code, code_err
  );

endinterface

// File: rtl/beat_sync_edge.sv
// Multi-flop synchronizer for a slow asynchronous strobe followed by a rising-edge
// detector; the pulse is one clock wide.
module beat_sync_edge #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [SyncStages-1:0] sync_q;
  logic                  last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < SyncStages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      last_q <= sync_q[SyncStages-1];
    end
  end

  assign pulse = sync_q[SyncStages-1] & ~last_q;

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave note generator: latches a note code on each beat, inserts an
// articulation gap before a new note, then toggles tone every half-period.
module note_tone_gen
  import note_pkg::*;
#(
  parameter int unsigned GAP_CYC     = GapCycDefault,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic            clk_5m,
  input logic            rst_n,
  note_tone_gen_if.slave bus
);

  localparam int unsigned     GapW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);

  logic                  beat_pulse;
  state_t                state_q, state_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic [HpW-1:0]        hp_cnt_q, hp_cnt_d;
  logic [HpW-1:0]        note_q, note_d;
  logic                  tone_q, tone_d;
  logic [2*CodeW-1:0]    cur_code_q, cur_code_d;
  logic                  code_err_q, code_err_d;
  logic                  en_q;
  logic [HpW-1:0]        new_hp, cur_hp, eff_hp;
  logic                  restart;

  beat_sync_edge #(
    .SyncStages(SYNC_STAGES)
  ) u_beat_sync (
    .clk     (clk_5m),
    .rst_n   (rst_n),
    .async_in(bus.beat),
    .pulse   (beat_pulse)
  );

  assign new_hp = hp_lookup(bus.med_code, bus.low_code);
  assign cur_hp = hp_lookup(cur_code_q[2*CodeW-1:CodeW], cur_code_q[CodeW-1:0]);
  assign eff_hp = beat_pulse ? new_hp : cur_hp;
  // An enable rising edge replays the latched code as if it were a fresh note.
  assign restart = !en_q || (beat_pulse && (new_hp != note_q));

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    hp_cnt_d   = hp_cnt_q;
    tone_d     = tone_q;
    note_d     = note_q;
    cur_code_d = cur_code_q;
    code_err_d = 1'b0;

    if (beat_pulse) begin
      cur_code_d = {bus.med_code, bus.low_code};
      code_err_d = ~code_valid(bus.med_code, bus.low_code);
    end

    unique case (state_q)
      StGap: begin
        if (gap_q == GapLast) begin
          state_d  = StPlay;
          hp_cnt_d = '0;
          tone_d   = 1'b0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StPlay: begin
        if (hp_cnt_q == note_q - 1'b1) begin
          hp_cnt_d = '0;
          tone_d   = ~tone_q;
        end else begin
          hp_cnt_d = hp_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (!bus.en) begin
      state_d  = StIdle;
      gap_d    = '0;
      hp_cnt_d = '0;
      tone_d   = 1'b0;
      note_d   = '0;
    end else if (restart) begin
      note_d   = eff_hp;
      gap_d    = '0;
      hp_cnt_d = '0;
      tone_d   = 1'b0;
      state_d  = (eff_hp == '0) ? StIdle : StGap;
    end
  end

  always_ff @(posedge clk_5m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gap_q      <= '0;
      hp_cnt_q   <= '0;
      tone_q     <= 1'b0;
      note_q     <= '0;
      cur_code_q <= '0;
      code_err_q <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      hp_cnt_q   <= hp_cnt_d;
      tone_q     <= tone_d;
      note_q     <= note_d;
      cur_code_q <= cur_code_d;
      code_err_q <= code_err_d;
      en_q       <= bus.en;
    end
  end

  assign bus.tone     = tone_q;
  assign bus.playing  = (state_q == StPlay);
  assign bus.cur_code = cur_code_q;
  assign bus.code_err = code_err_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen: latch timing, gap/period lengths, sustain,
// note switching, rests, invalid codes, reset and enable handling.
module tb_note_tone_gen;

  logic clk_5m = 1'b0;
  logic rst_n  = 1'b1;

  note_tone_gen_if bus ();

  note_tone_gen #(
    .GAP_CYC    (2500),
    .SYNC_STAGES(2)
  ) dut (
    .clk_5m(clk_5m),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #100 clk_5m = ~clk_5m;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_edge = 0;
  int   n_edges = 0;
  int   mon_hp = 0;
  int   beat_len = 0;
  int   e0 = 0;
  bit   mon_en = 1'b0;
  logic tone_last = 1'b0;
  logic tone_pre;
  logic err_pre;
  logic [7:0] code_pre;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Tone edge monitor and beat de-assertion, both on the falling clock edge.
  initial forever begin
    @(negedge clk_5m);
    cyc++;
    if (beat_len > 0) begin
      beat_len--;
      if (beat_len == 0) bus.beat = 1'b0;
    end
    if (bus.tone !== tone_last) begin
      if (mon_en) check("tone_spacing", cyc - last_edge, mon_hp);
      last_edge = cyc;
      tone_last = bus.tone;
      n_edges++;
    end
  end

  // Counts rising clock edges until the chosen output reaches val.
  task automatic wait_for(input string tag, input bit sel_tone, input logic val,
                          input int budget, input int exp);
    int   n;
    logic s;
    n = 0;
    do begin
      @(posedge clk_5m);
      #1;
      n++;
      s = sel_tone ? bus.tone : bus.playing;
    end while (s !== val && n < budget);
    check(tag, n, exp);
  endtask

  // Raises beat with the given code; returns 1 time unit after the latching edge.
  task automatic beat_latch(input logic [3:0] med, input logic [3:0] low);
    @(negedge clk_5m);
    bus.med_code = med;
    bus.low_code = low;
    bus.beat     = 1'b1;
    beat_len     = 6;
    repeat (2) @(posedge clk_5m);
    #1;
    tone_pre = bus.tone;
    code_pre = bus.cur_code;
    err_pre  = bus.code_err;
    @(posedge clk_5m);
    #1;
  endtask

  initial begin
    bus.beat     = 1'b0;
    bus.en       = 1'b0;
    bus.med_code = 4'd0;
    bus.low_code = 4'd0;
    #5 rst_n = 1'b0;
    #1;
    check("rst_tone", bus.tone, 0);
    check("rst_playing", bus.playing, 0);
    check("rst_cur_code", bus.cur_code, 8'h00);
    check("rst_code_err", bus.code_err, 0);
    repeat (3) @(posedge clk_5m);
    #1 rst_n = 1'b1;
    bus.en = 1'b1;
    repeat (5) @(posedge clk_5m);

    // Start of sol (0x50): latch on 3rd edge, 2500-cycle gap, 6378-cycle half-period.
    beat_latch(4'd5, 4'd0);
    check("a_pre_latch_code", code_pre, 8'h00);
    check("a_latch_code", bus.cur_code, 8'h50);
    check("a_gap_playing", bus.playing, 0);
    wait_for("a_gap_len", 1'b0, 1'b1, 3000, 2500);
    check("a_play_tone0", bus.tone, 0);
    wait_for("a_first_half", 1'b1, 1'b1, 7000, 6378);
    @(negedge clk_5m);
    #1;
    mon_hp = 6378;
    mon_en = 1'b1;

    // Sustain: same code on successive beats leaves the phase untouched.
    e0 = n_edges;
    repeat (4) begin
      repeat (2000) @(posedge clk_5m);
      beat_latch(4'd5, 4'd0);
      check("b_sustain_code", bus.cur_code, 8'h50);
      check("b_sustain_playing", bus.playing, 1);
    end
    check("b_edges", n_edges - e0, 1);
    mon_en = 1'b0;

    // Enable dropped for 1000 cycles, then a fresh gap and phase-0 restart.
    bus.en = 1'b0;
    @(posedge clk_5m);
    #1;
    check("f_en_low_tone", bus.tone, 0);
    check("f_en_low_playing", bus.playing, 0);
    e0 = n_edges;
    repeat (999) @(posedge clk_5m);
    #1;
    check("f_en_low_edges", n_edges - e0, 0);
    bus.en = 1'b1;
    @(posedge clk_5m);
    #1;
    check("f_regap_playing", bus.playing, 0);
    wait_for("f_gap_len", 1'b0, 1'b1, 3000, 2500);
    wait_for("f_restart_half", 1'b1, 1'b1, 7000, 6378);

    // Asynchronous reset in the middle of a high half-period.
    repeat (100) @(posedge clk_5m);
    #1;
    check("e_pre_tone", bus.tone, 1);
    check("e_pre_playing", bus.playing, 1);
    rst_n = 1'b0;
    #1;
    check("e_rst_tone", bus.tone, 0);
    check("e_rst_playing", bus.playing, 0);
    check("e_rst_cur_code", bus.cur_code, 8'h00);
    check("e_rst_code_err", bus.code_err, 0);
    repeat (3) @(posedge clk_5m);
    #1 rst_n = 1'b1;
    e0 = n_edges;
    repeat (2000) @(posedge clk_5m);
    #1;
    check("e_post_playing", bus.playing, 0);
    check("e_post_edges", n_edges - e0, 0);

    // Mi (0x30), then switch to low do (0x01) partway through a high half-period.
    beat_latch(4'd3, 4'd0);
    check("c_mi_code", bus.cur_code, 8'h30);
    wait_for("c_mi_gap", 1'b0, 1'b1, 3000, 2500);
    wait_for("c_mi_half", 1'b1, 1'b1, 9000, 7584);
    repeat (2000) @(posedge clk_5m);
    beat_latch(4'd0, 4'd1);
    check("c_switch_pre_tone", tone_pre, 1);
    check("c_switch_tone", bus.tone, 0);
    check("c_switch_playing", bus.playing, 0);
    check("c_switch_code", bus.cur_code, 8'h01);
    wait_for("c_low_gap", 1'b0, 1'b1, 3000, 2500);
    wait_for("c_low_lo_half", 1'b1, 1'b1, 20000, 19110);
    wait_for("c_low_hi_half", 1'b1, 1'b0, 20000, 19110);

    // Rest and invalid code pairs.
    repeat (100) @(posedge clk_5m);
    #1;
    check("d_pre_playing", bus.playing, 1);
    beat_latch(4'd0, 4'd0);
    check("d_rest_playing", bus.playing, 0);
    check("d_rest_tone", bus.tone, 0);
    check("d_rest_code", bus.cur_code, 8'h00);
    check("d_rest_err", bus.code_err, 0);
    repeat (20) @(posedge clk_5m);
    beat_latch(4'd9, 4'd3);
    check("d_93_err_pre", err_pre, 0);
    check("d_93_err", bus.code_err, 1);
    check("d_93_code", bus.cur_code, 8'h93);
    @(posedge clk_5m);
    #1;
    check("d_93_err_end", bus.code_err, 0);
    repeat (20) @(posedge clk_5m);
    beat_latch(4'd2, 4'd1);
    check("d_21_err", bus.code_err, 1);
    check("d_21_code", bus.cur_code, 8'h21);
    @(posedge clk_5m);
    #1;
    check("d_21_err_end", bus.code_err, 0);
    e0 = n_edges;
    repeat (2600) @(posedge clk_5m);
    #1;
    check("d_21_rest_playing", bus.playing, 0);
    check("d_21_rest_edges", n_edges - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
